// File: rtl/dma_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_irq_pkg
//  Description : Shared definitions for the DMA interrupt coalescer: register
//                offsets and decode indices, channel indices and the
//                per-channel coalescing state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_irq_pkg;

    // Register byte offsets (8-byte aligned, 64-bit registers)
    localparam logic [5:0] IPSR_OFFS    = 6'h00;
    localparam logic [5:0] IER_OFFS     = 6'h08;
    localparam logic [5:0] THRESH_OFFS  = 6'h10;
    localparam logic [5:0] TIMEOUT_OFFS = 6'h18;
    localparam logic [5:0] CNT_OFFS     = 6'h20;

    // Word indices used by the decoder (address bits [5:3])
    localparam logic [2:0] IPSR_IDX    = IPSR_OFFS[5:3];
    localparam logic [2:0] IER_IDX     = IER_OFFS[5:3];
    localparam logic [2:0] THRESH_IDX  = THRESH_OFFS[5:3];
    localparam logic [2:0] TIMEOUT_IDX = TIMEOUT_OFFS[5:3];
    localparam logic [2:0] CNT_IDX     = CNT_OFFS[5:3];

    // Channel indices into irq_o / IPSR / IER
    localparam int unsigned IRQ_RD = 0;
    localparam int unsigned IRQ_WR = 1;
    localparam int unsigned NUM_CH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PEND  = 2'd2
    } coal_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_irq_coalesce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : dma_irq_coalesce_ch
//  Description : One interrupt-coalescing channel. Counts completion events,
//                fires a pending flag on a count threshold or an idle timeout,
//                and keeps counting while pending until software clears it.
//  Ports       : clk_i, rst_i   - clock, synchronous active-high reset
//                evt_i          - one-cycle completion pulse
//                thr_i          - count threshold (0 behaves as 1)
//                timeout_i      - idle timeout in cycles (0 disables)
//                clr_i          - write-1-to-clear of the pending flag
//                pend_o         - pending flag
//                cnt_o          - current event count
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_irq_coalesce_ch
    import dma_irq_pkg::*;
#(
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned TimerWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  evt_i,
    input  logic [CntWidth-1:0]   thr_i,
    input  logic [TimerWidth-1:0] timeout_i,
    input  logic                  clr_i,
    output logic                  pend_o,
    output logic [CntWidth-1:0]   cnt_o
);

    localparam logic [CntWidth-1:0]   CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0]   CNT_MAX = '1;
    localparam logic [TimerWidth-1:0] TMR_ONE = {{(TimerWidth-1){1'b0}}, 1'b1};
    localparam logic [TimerWidth-1:0] TMR_MAX = '1;

    coal_state_e           state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [TimerWidth-1:0] tmr_q, tmr_d;

    logic [CntWidth-1:0]   cnt_nxt;
    logic [TimerWidth-1:0] tmr_nxt;
    logic [CntWidth-1:0]   thr_eff;
    logic                  hit_cnt;
    logic                  hit_tmr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

    // Candidate next count/timer, both saturating. An event restarts the
    // idle timer.
    assign cnt_nxt = evt_i ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE) : cnt_q;
    assign tmr_nxt = evt_i ? '0 : ((tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_ONE);

    // A zero threshold would otherwise fire with no events at all.
    assign thr_eff = (thr_i == '0) ? CNT_ONE : thr_i;
    assign hit_cnt = ({1'b0, cnt_nxt} >= {1'b0, thr_eff});
    assign hit_tmr = (timeout_i != '0) && (tmr_nxt >= timeout_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        case (state_q)
            // IDLE behaves like ACCUM with a zero count once an event
            // arrives, so a threshold of 1 fires on the very first pulse.
            IDLE, ACCUM: begin
                if ((state_q == ACCUM) || evt_i) begin
                    if (hit_cnt || hit_tmr) begin
                        // The current event (if any) belongs to the fired batch.
                        state_d = PEND;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        state_d = ACCUM;
                        cnt_d   = cnt_nxt;
                        tmr_d   = tmr_nxt;
                    end
                end
            end
            PEND: begin
                cnt_d = cnt_nxt;
                tmr_d = '0;
                // Leaving with a count at/above threshold re-fires one cycle
                // later through the ACCUM compare.
                if (clr_i) begin
                    state_d = (cnt_nxt != '0) ? ACCUM : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    assign pend_o = (state_q == PEND);
    assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dma_irq_coalesce.sv
`default_nettype none
// ============================================================================
//  Module      : dma_irq_coalesce
//  Description : DMA completion interrupt coalescer. Two channels (read and
//                write burst completion) with shared timeout, per-channel
//                thresholds, W1C pending bits and maskable interrupt lines.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                r_done_i, w_done_i  - completion pulses
//                reg_*               - single-cycle 64-bit register port
//                irq_o[1:0]          - [0] read channel, [1] write channel
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_irq_coalesce
    import dma_irq_pkg::*;
#(
    parameter int unsigned CntWidth     = 16,
    parameter int unsigned TimerWidth   = 32,
    parameter int unsigned RegAddrWidth = 6,
    parameter int unsigned RegDataWidth = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      r_done_i,
    input  logic                      w_done_i,
    input  logic                      reg_valid_i,
    input  logic                      reg_write_i,
    input  logic [RegAddrWidth-1:0]   reg_addr_i,
    input  logic [RegDataWidth-1:0]   reg_wdata_i,
    input  logic [RegDataWidth/8-1:0] reg_wstrb_i,
    output logic                      reg_ready_o,
    output logic [RegDataWidth-1:0]   reg_rdata_o,
    output logic                      reg_error_o,
    output logic [1:0]                irq_o
);

    localparam logic [CntWidth-1:0] THR_RST = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [1:0]            ier_q, ier_d;
    logic [CntWidth-1:0]   thr_rd_q, thr_rd_d;
    logic [CntWidth-1:0]   thr_wr_q, thr_wr_d;
    logic [TimerWidth-1:0] timeout_q, timeout_d;

    logic [2:0]              idx;
    logic                    mapped;
    logic                    wr_en;
    logic [RegDataWidth-1:0] bmask;
    logic [RegDataWidth-1:0] rdata;
    logic [NUM_CH-1:0]       evt;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       pend;
    logic [CntWidth-1:0]     thr [NUM_CH];
    logic [CntWidth-1:0]     cnt [NUM_CH];
    logic                    unused_bits;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    assign idx    = reg_addr_i[5:3];
    assign mapped = (idx <= CNT_IDX);
    assign wr_en  = reg_valid_i & reg_write_i & mapped;

    for (genvar b = 0; b < RegDataWidth/8; b++) begin : g_bmask
        assign bmask[b*8 +: 8] = {8{reg_wstrb_i[b]}};
    end

    // IPSR is write-1-to-clear; only strobed bytes participate.
    assign clr = (wr_en && (idx == IPSR_IDX)) ? (reg_wdata_i[NUM_CH-1:0] & bmask[NUM_CH-1:0])
                                               : '0;

    always_comb begin
        ier_d     = ier_q;
        thr_rd_d  = thr_rd_q;
        thr_wr_d  = thr_wr_q;
        timeout_d = timeout_q;
        if (wr_en) begin
            case (idx)
                IER_IDX: begin
                    ier_d = (ier_q & ~bmask[1:0]) | (reg_wdata_i[1:0] & bmask[1:0]);
                end
                THRESH_IDX: begin
                    thr_rd_d = (thr_rd_q & ~bmask[CntWidth-1:0])
                             | (reg_wdata_i[CntWidth-1:0] & bmask[CntWidth-1:0]);
                    thr_wr_d = (thr_wr_q & ~bmask[16 +: CntWidth])
                             | (reg_wdata_i[16 +: CntWidth] & bmask[16 +: CntWidth]);
                end
                TIMEOUT_IDX: begin
                    timeout_d = (timeout_q & ~bmask[TimerWidth-1:0])
                              | (reg_wdata_i[TimerWidth-1:0] & bmask[TimerWidth-1:0]);
                end
                default: begin
                    // IPSR handled via clr; CNT is read-only.
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ier_q     <= '0;
            thr_rd_q  <= THR_RST;
            thr_wr_q  <= THR_RST;
            timeout_q <= '0;
        end else begin
            ier_q     <= ier_d;
            thr_rd_q  <= thr_rd_d;
            thr_wr_q  <= thr_wr_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            IPSR_IDX:    rdata[NUM_CH-1:0] = pend;
            IER_IDX:     rdata[1:0] = ier_q;
            THRESH_IDX: begin
                rdata[CntWidth-1:0]   = thr_rd_q;
                rdata[16 +: CntWidth] = thr_wr_q;
            end
            TIMEOUT_IDX: rdata[TimerWidth-1:0] = timeout_q;
            CNT_IDX: begin
                rdata[CntWidth-1:0]   = cnt[IRQ_RD];
                rdata[16 +: CntWidth] = cnt[IRQ_WR];
            end
            default:     rdata = '0;
        endcase
    end

    assign reg_ready_o = 1'b1;
    assign reg_rdata_o = rdata;
    assign reg_error_o = reg_valid_i & ~mapped;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    assign evt[IRQ_RD] = r_done_i;
    assign evt[IRQ_WR] = w_done_i;
    assign thr[IRQ_RD] = thr_rd_q;
    assign thr[IRQ_WR] = thr_wr_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        dma_irq_coalesce_ch #(
            .CntWidth   (CntWidth),
            .TimerWidth (TimerWidth)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .evt_i     (evt[ch]),
            .thr_i     (thr[ch]),
            .timeout_i (timeout_q),
            .clr_i     (clr[ch]),
            .pend_o    (pend[ch]),
            .cnt_o     (cnt[ch])
        );
    end

    // Flop-driven only, so no input-to-output glitch path.
    assign irq_o = pend & ier_q;

    assign unused_bits = ^{reg_addr_i, reg_wdata_i, bmask};

endmodule
`default_nettype wire

// File: tb/tb_dma_irq_coalesce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_irq_coalesce
//  Description : Self-checking bench for dma_irq_coalesce. Directed scenarios
//                followed by random traffic, all compared against a
//                cycle-level behavioural model of the coalescing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_irq_coalesce;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        r_done_i, w_done_i;
    logic        reg_valid_i, reg_write_i;
    logic [5:0]  reg_addr_i;
    logic [63:0] reg_wdata_i;
    logic [7:0]  reg_wstrb_i;
    logic        reg_ready_o;
    logic [63:0] reg_rdata_o;
    logic        reg_error_o;
    logic [1:0]  irq_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    dma_irq_coalesce dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .r_done_i    (r_done_i),
        .w_done_i    (w_done_i),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_ready_o (reg_ready_o),
        .reg_rdata_o (reg_rdata_o),
        .reg_error_o (reg_error_o),
        .irq_o       (irq_o)
    );

    // ---------------- behavioural model ----------------
    localparam int     CMAX = 65535;
    localparam longint TMAX = 64'd4294967295;

    bit     m_pend [2];
    int     m_cnt  [2];
    longint m_tmr  [2];
    int     m_thr  [2];
    bit [1:0] m_ier;
    longint m_to;

    logic [63:0] obs_rdata;
    logic [1:0]  obs_irq;
    logic        obs_err;

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0; m_cnt[c] = 0; m_tmr[c] = 0; m_thr[c] = 1;
        end
        m_ier = 0;
        m_to  = 0;
    endfunction

    function automatic bit m_mapped(input logic [5:0] a);
        return (a >= 6'h00) && (a < 6'h28);
    endfunction

    function automatic logic [63:0] m_read(input logic [5:0] a);
        logic [63:0] v = 64'd0;
        if (a < 6'h08)      v = {62'd0, m_pend[1], m_pend[0]};
        else if (a < 6'h10) v = {62'd0, m_ier};
        else if (a < 6'h18) v = {32'd0, 16'(m_thr[1]), 16'(m_thr[0])};
        else if (a < 6'h20) v = {32'd0, 32'(m_to)};
        else if (a < 6'h28) v = {32'd0, 16'(m_cnt[1]), 16'(m_cnt[0])};
        return v;
    endfunction

    function automatic logic [63:0] wmerge(input logic [63:0] old, input logic [63:0] d,
                                           input logic [7:0] s);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Advance the model by one clock edge with the inputs applied this cycle.
    function automatic void m_clock(input bit r, input bit w, input bit rst, input bit valid,
                                    input bit wr, input logic [5:0] a, input logic [63:0] d,
                                    input logic [7:0] s);
        bit ev [2];
        bit [1:0] clr;
        logic [63:0] v;
        if (rst) begin
            m_reset();
            return;
        end
        ev[0] = r; ev[1] = w;
        clr = (valid && wr && a < 6'h08 && s[0]) ? d[1:0] : 2'b00;
        for (int c = 0; c < 2; c++) begin
            int thr_eff = (m_thr[c] == 0) ? 1 : m_thr[c];
            if (m_pend[c]) begin
                if (ev[c] && m_cnt[c] < CMAX) m_cnt[c]++;
                m_tmr[c] = 0;
                if (clr[c]) m_pend[c] = 0;
            end else if (m_cnt[c] != 0 || ev[c]) begin
                if (ev[c]) begin
                    if (m_cnt[c] < CMAX) m_cnt[c]++;
                    m_tmr[c] = 0;
                end else if (m_tmr[c] < TMAX) begin
                    m_tmr[c]++;
                end
                if (m_cnt[c] >= thr_eff || (m_to != 0 && m_tmr[c] >= m_to)) begin
                    m_pend[c] = 1; m_cnt[c] = 0; m_tmr[c] = 0;
                end
            end
        end
        if (valid && wr && m_mapped(a)) begin
            v = wmerge(m_read(a), d, s);
            if (a >= 6'h08 && a < 6'h10) m_ier = v[1:0];
            if (a >= 6'h10 && a < 6'h18) begin
                m_thr[0] = int'(v[15:0]);
                m_thr[1] = int'(v[31:16]);
            end
            if (a >= 6'h18 && a < 6'h20) m_to = longint'(v[31:0]);
        end
    endfunction

    // ---------------- checking / stimulus helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rst, input bit valid, input bit wr,
                        input logic [5:0] a, input logic [63:0] d, input logic [7:0] s);
        r_done_i = r; w_done_i = w; rst_i = rst;
        reg_valid_i = valid; reg_write_i = wr;
        reg_addr_i = a; reg_wdata_i = d; reg_wstrb_i = s;
        @(negedge clk_i);
        obs_rdata = reg_rdata_o;
        obs_irq   = irq_o;
        obs_err   = reg_error_o;
        check("irq", {62'd0, irq_o}, {62'd0, m_pend[1] & m_ier[1], m_pend[0] & m_ier[0]});
        if (valid && !wr) check($sformatf("rdata@%0h", a), reg_rdata_o, m_read(a));
        if (valid) check($sformatf("error@%0h", a), {63'd0, reg_error_o}, {63'd0, !m_mapped(a)});
        @(posedge clk_i);
        m_clock(r, w, rst, valid, wr, a, d, s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 6'h0, 64'd0, 8'h00);
    endtask
    task automatic wreg(input logic [5:0] a, input logic [63:0] d);
        step(0, 0, 0, 1, 1, a, d, 8'hFF);
    endtask
    task automatic rreg(input logic [5:0] a);
        step(0, 0, 0, 1, 0, a, 64'd0, 8'h00);
    endtask
    task automatic pulses(input bit rd, input int n);
        for (int i = 0; i < n; i++) step(rd, !rd, 0, 0, 0, 6'h0, 64'd0, 8'h00);
    endtask

    initial begin
        rst_i = 1; r_done_i = 0; w_done_i = 0; reg_valid_i = 0; reg_write_i = 0;
        reg_addr_i = 0; reg_wdata_i = 0; reg_wstrb_i = 0;
        repeat (2) @(posedge clk_i);
        m_reset();
        #1;

        // Reset values
        rreg(6'h00); check("rst_ipsr", obs_rdata, 64'h0);
        check("ready", {63'd0, reg_ready_o}, 64'h1);
        rreg(6'h08); check("rst_ier", obs_rdata, 64'h0);
        rreg(6'h10); check("rst_thresh", obs_rdata, 64'h0001_0001);
        rreg(6'h18); check("rst_timeout", obs_rdata, 64'h0);
        rreg(6'h20); check("rst_cnt", obs_rdata, 64'h0);
        rreg(6'h28); check("unmapped_err", {63'd0, obs_err}, 64'h1);
        check("unmapped_rdata", obs_rdata, 64'h0);
        check("rst_irq", {62'd0, obs_irq}, 64'h0);

        // Read threshold of 4, pulses every other cycle
        wreg(6'h08, 64'h3);
        wreg(6'h10, 64'h0008_0004);
        for (int i = 0; i < 4; i++) begin
            pulses(1, 1);
            if (i < 3) idle(1);
        end
        rreg(6'h20);
        check("rd_thr_irq", {62'd0, obs_irq}, 64'h1);
        check("rd_thr_cnt", {48'd0, obs_rdata[15:0]}, 64'h0);
        wreg(6'h00, 64'h1);
        idle(1); check("rd_w1c_irq", {63'd0, obs_irq[0]}, 64'h0);

        // Idle timeout on the write channel
        wreg(6'h18, 64'd20);
        pulses(0, 1); idle(1); pulses(0, 1); idle(1); pulses(0, 1);
        idle(20); check("tmo_not_yet", {63'd0, obs_irq[1]}, 64'h0);
        idle(1);  check("tmo_fire", {63'd0, obs_irq[1]}, 64'h1);
        rreg(6'h20); check("tmo_cnt", {48'd0, obs_rdata[31:16]}, 64'h0);
        wreg(6'h00, 64'h2);

        // TIMEOUT=0 disables the timer
        wreg(6'h18, 64'd0);
        pulses(0, 3); idle(40);
        rreg(6'h00); check("no_tmo_ipsr", obs_rdata, 64'h0);
        rreg(6'h20); check("no_tmo_cnt", obs_rdata, 64'h0003_0000);

        // Accumulate while pending, re-fire after clear
        pulses(0, 5);
        pulses(0, 10);
        rreg(6'h20); check("pend_accum_cnt", {48'd0, obs_rdata[31:16]}, 64'd10);
        wreg(6'h00, 64'h2);
        rreg(6'h00); check("refire_gap", {63'd0, obs_rdata[1]}, 64'h0);
        rreg(6'h00); check("refire_set", {63'd0, obs_rdata[1]}, 64'h1);
        rreg(6'h20); check("refire_cnt", {48'd0, obs_rdata[31:16]}, 64'h0);
        wreg(6'h00, 64'h2);

        // W1C in the same cycle as a fire: set wins
        pulses(1, 3);
        step(1, 0, 0, 1, 1, 6'h00, 64'h1, 8'hFF);
        rreg(6'h00); check("set_wins", {63'd0, obs_rdata[0]}, 64'h1);
        wreg(6'h00, 64'h1);

        // Masked channel still sets pend
        wreg(6'h08, 64'h0);
        pulses(1, 4);
        rreg(6'h00); check("mask_pend", {63'd0, obs_rdata[0]}, 64'h1);
        check("mask_irq", {62'd0, obs_irq}, 64'h0);
        wreg(6'h08, 64'h1);
        idle(1); check("unmask_irq", {63'd0, obs_irq[0]}, 64'h1);
        wreg(6'h00, 64'h1);
        wreg(6'h08, 64'h3);

        // Threshold lowered below the running count
        wreg(6'h10, 64'h0008_0008);
        pulses(1, 5);
        wreg(6'h10, 64'h0008_0002);
        idle(1);
        rreg(6'h00); check("thr_lowered", {63'd0, obs_rdata[0]}, 64'h1);
        wreg(6'h00, 64'h1);
        wreg(6'h10, 64'h0008_0004);

        // Reset mid-accumulation together with a pulse
        pulses(1, 3);
        rreg(6'h20); check("pre_rst_cnt", {48'd0, obs_rdata[15:0]}, 64'd3);
        step(1, 0, 1, 0, 0, 6'h0, 64'd0, 8'h00);
        rreg(6'h20); check("post_rst_cnt", obs_rdata, 64'h0);
        rreg(6'h10); check("post_rst_thresh", obs_rdata, 64'h0001_0001);
        rreg(6'h08); check("post_rst_ier", obs_rdata, 64'h0);

        // Byte strobes
        step(0, 0, 0, 1, 1, 6'h10, 64'hFFFF_FFFF_FFFF_FF05, 8'h01);
        rreg(6'h10); check("strobe_thresh", obs_rdata, 64'h0001_0005);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r   = ($urandom % 4) == 0;
            bit          w   = ($urandom % 3) == 0;
            bit          rst = ($urandom % 700) == 0;
            bit          v   = ($urandom % 4) == 0;
            bit          wr  = $urandom % 2;
            logic [5:0]  a   = 6'(($urandom % 8) * 8);
            logic [63:0] d   = {$urandom, $urandom};
            logic [7:0]  s   = (($urandom % 4) == 0) ? 8'($urandom) : 8'hFF;
            if (a == 6'h10) d = {32'd0, 16'($urandom % 7), 16'($urandom % 7)};
            if (a == 6'h18) d = {32'd0, 32'((($urandom % 2) == 0) ? 0 : $urandom % 15)};
            step(r, w, rst, v, wr, a, d, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
